// File: rtl/sha3_padder.sv
// ---------------------------------------------------------------------------
// sha3_padder
//
// Absorber front-end for the SHA3 core. Packs a little-endian 64-bit word
// stream into a 1152-bit rate block, applies SHA3 domain padding
// (0x06 ... 0x80) at the end of a message, and presents each finished block,
// together with the message mode, to the state-XOR stage.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_mode    hash select, latched with the first word of a message
//              (00 SHA3-512, 01 SHA3-384, 10 SHA3-224, 11 SHA3-256)
//   in_valid   word valid
//   in_ready   word accepted on in_valid & in_ready (high only while filling)
//   in_data    message word, byte k at bits [8k+7:8k]
//   in_last    final word of the message
//   in_bytes   valid low bytes of the final word (0..8, >8 means 8)
//   out_block  padded rate block, lane j at bits [64j+63:64j]
//   out_mode   mode of the message the block belongs to
//   out_last   block is the final block of its message
//   out_valid  block valid
//   out_ready  block consumed on out_valid & out_ready
// ---------------------------------------------------------------------------
module sha3_padder (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    in_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic          in_last,
  input  logic [3:0]    in_bytes,
  output logic [1151:0] out_block,
  output logic [1:0]    out_mode,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [1:0] {
    FILL         = 2'd0,
    FULL         = 2'd1,
    FULL_PADNEXT = 2'd2
  } state_e;

  localparam int NumLanes = 18;

  state_e          state_q, state_d;
  logic [1151:0]   buf_q, buf_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic            inMsg_q, inMsg_d;
  logic            last_q, last_d;

  logic [1:0]      effMode;
  logic [4:0]      rLast;
  logic [4:0]      rLastHeld;
  logic [3:0]      validBytes;
  logic [63:0]     maskedWord;
  logic [4:0]      padLane;
  logic [2:0]      padByte;

  // Rate in 64-bit lanes for each mode encoding.
  function automatic logic [4:0] rateLanes(input logic [1:0] m);
    case (m)
      2'b00:   rateLanes = 5'd9;
      2'b01:   rateLanes = 5'd13;
      2'b10:   rateLanes = 5'd18;
      default: rateLanes = 5'd17;
    endcase
  endfunction

  // The mode only comes from in_mode on the first word of a message; after
  // that the latched copy governs the rate.
  assign effMode   = inMsg_q ? mode_q : in_mode;
  assign rLast     = rateLanes(effMode) - 5'd1;
  assign rLastHeld = rateLanes(mode_q) - 5'd1;

  // Non-final words always carry 8 bytes; oversize byte counts saturate.
  assign validBytes = (!in_last || (in_bytes > 4'd8)) ? 4'd8 : in_bytes;

  // A full final word pushes the 0x06 pad byte to byte 0 of the next lane.
  assign padLane = (validBytes == 4'd8) ? (cnt_q + 5'd1) : cnt_q;
  assign padByte = (validBytes == 4'd8) ? 3'd0 : validBytes[2:0];

  always_comb begin
    maskedWord = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < validBytes) maskedWord[8*k +: 8] = in_data[8*k +: 8];
    end
  end

  // Next-state and datapath. Lanes beyond the current count are always zero
  // (the buffer is cleared on every handshake), so padding can simply be
  // OR-ed in; 0x06 and 0x80 landing on one byte naturally merge into 0x86.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    inMsg_d = inMsg_q;
    last_d  = last_q;

    case (state_q)
      FILL: begin
        if (in_valid) begin
          mode_d  = effMode;
          inMsg_d = 1'b1;
          for (int j = 0; j < NumLanes; j++) begin
            if (5'(j) == cnt_q) buf_d[64*j +: 64] = maskedWord;
          end
          if (!in_last) begin
            if (cnt_q == rLast) begin
              state_d = FULL;
              last_d  = 1'b0;
              cnt_d   = 5'd0;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else if ((validBytes == 4'd8) && (cnt_q == rLast)) begin
            // Block is full of message data; the pad goes in a block of its own.
            state_d = FULL_PADNEXT;
            last_d  = 1'b0;
            cnt_d   = 5'd0;
          end else begin
            for (int j = 0; j < NumLanes; j++) begin
              for (int k = 0; k < 8; k++) begin
                if ((5'(j) == padLane) && (3'(k) == padByte))
                  buf_d[64*j + 8*k +: 8] = buf_d[64*j + 8*k +: 8] | 8'h06;
              end
              if (5'(j) == rLast)
                buf_d[64*j + 56 +: 8] = buf_d[64*j + 56 +: 8] | 8'h80;
            end
            state_d = FULL;
            last_d  = 1'b1;
            cnt_d   = 5'd0;
          end
        end
      end

      FULL: begin
        if (out_ready) begin
          buf_d   = '0;
          cnt_d   = 5'd0;
          state_d = FILL;
          last_d  = 1'b0;
          if (last_q) inMsg_d = 1'b0;
        end
      end

      FULL_PADNEXT: begin
        if (out_ready) begin
          buf_d        = '0;
          buf_d[7:0]   = 8'h06;
          for (int j = 0; j < NumLanes; j++) begin
            if (5'(j) == rLastHeld) buf_d[64*j + 56 +: 8] = 8'h80;
          end
          state_d = FULL;
          last_d  = 1'b1;
        end
      end

      default: state_d = FILL;
    endcase
  end

  // All state lives here; outputs are taken straight from these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= 5'd0;
      mode_q  <= 2'b00;
      inMsg_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      inMsg_q <= inMsg_d;
      last_q  <= last_d;
    end
  end

  // Handshake signals decode only the state register, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q != FILL);
  assign out_block = buf_q;
  assign out_mode  = mode_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_sha3_padder.sv
// ---------------------------------------------------------------------------
// tb_sha3_padder
//
// Directed self-checking bench for sha3_padder: empty message, "abc",
// single-block boundary pad (0x86), full-block message needing a pad-only
// block, multi-block message under backpressure, and reset mid-message.
// ---------------------------------------------------------------------------
module tb_sha3_padder;

  logic          clk;
  logic          rst_n;
  logic [1:0]    in_mode;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic [1151:0] out_block;
  logic [1:0]    out_mode;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [1151:0] expBlk;
  logic [1151:0] heldBlk;

  sha3_padder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .out_block (out_block),
    .out_mode  (out_mode),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Distinct per-index word with a non-zero top byte so byte masking shows.
  function automatic logic [63:0] wordPat(input int i);
    wordPat = {8'(i + 1), 8'hA5, 16'hBEEF, 32'(i * 3 + 7)};
  endfunction

  // Present one word for exactly one rising edge (driven at the falling edge).
  task automatic applyStimulus(input logic [63:0] data, input logic last,
                               input logic [3:0] nbytes, input logic [1:0] mode);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    in_bytes = nbytes;
    in_mode  = mode;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Hold out_ready for exactly one rising edge.
  task automatic consumeBlock();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Scalar / narrow comparison.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-block comparison; reports the first differing lane to keep lines short.
  task automatic checkBlockOutput(input string tag, input logic [1151:0] obs,
                                  input logic [1151:0] exp);
    int badLane;
    badLane = -1;
    for (int j = 17; j >= 0; j--) begin
      if (obs[64*j +: 64] !== exp[64*j +: 64]) badLane = j;
    end
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      if (badLane >= 0)
        $error("[TB] FAIL %s: lane %0d got %0h expected %0h", tag, badLane,
               obs[64*badLane +: 64], exp[64*badLane +: 64]);
      else
        $error("[TB] FAIL %s: block differs", tag);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = 4'd0;
    out_ready = 1'b0;

    // Reset values while rst_n is held low.
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_last",  64'(out_last),  64'd0);
    checkOutput("rst_out_mode",  64'(out_mode),  64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
    checkBlockOutput("rst_out_block", out_block, '0);
    rst_n = 1'b1;

    // Empty message, SHA3-256: pad-only block, rate 17 lanes.
    applyStimulus(64'h0, 1'b1, 4'd0, 2'b11);
    @(negedge clk);
    expBlk = '0;
    expBlk[0 +: 64]      = 64'h0000000000000006;
    expBlk[64*16 +: 64]  = 64'h8000000000000000;
    checkOutput("empty_valid", 64'(out_valid), 64'd1);
    checkOutput("empty_in_ready", 64'(in_ready), 64'd0);
    checkOutput("empty_last", 64'(out_last), 64'd1);
    checkOutput("empty_mode", 64'(out_mode), 64'd3);
    checkBlockOutput("empty_block", out_block, expBlk);
    consumeBlock();
    @(negedge clk);
    checkOutput("empty_done_valid", 64'(out_valid), 64'd0);
    checkOutput("empty_done_ready", 64'(in_ready), 64'd1);

    // "abc", SHA3-512: rate 9 lanes.
    applyStimulus(64'h0000000000636261, 1'b1, 4'd3, 2'b00);
    @(negedge clk);
    expBlk = '0;
    expBlk[0 +: 64]     = 64'h0000000006636261;
    expBlk[64*8 +: 64]  = 64'h8000000000000000;
    checkOutput("abc_valid", 64'(out_valid), 64'd1);
    checkOutput("abc_last", 64'(out_last), 64'd1);
    checkOutput("abc_mode", 64'(out_mode), 64'd0);
    checkBlockOutput("abc_block", out_block, expBlk);
    consumeBlock();

    // SHA3-224, 18 words, last with 7 bytes: 0x06 and 0x80 merge to 0x86.
    expBlk = '0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(wordPat(i), (i == 17), (i == 17) ? 4'd7 : 4'd8, 2'b10);
      expBlk[64*i +: 64] = wordPat(i);
      if (i == 5) begin
        @(negedge clk);
        checkOutput("b224_mid_valid", 64'(out_valid), 64'd0);
        checkOutput("b224_mid_ready", 64'(in_ready), 64'd1);
      end
    end
    expBlk[64*17 + 56 +: 8] = 8'h86;
    @(negedge clk);
    checkOutput("b224_valid", 64'(out_valid), 64'd1);
    checkOutput("b224_last", 64'(out_last), 64'd1);
    checkOutput("b224_mode", 64'(out_mode), 64'd2);
    checkBlockOutput("b224_block", out_block, expBlk);
    consumeBlock();
    @(negedge clk);
    checkOutput("b224_single", 64'(out_valid), 64'd0);

    // SHA3-512, exactly 9 full words ending the message: pad-only block follows.
    expBlk = '0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(wordPat(i + 40), (i == 8), 4'd8, 2'b00);
      expBlk[64*i +: 64] = wordPat(i + 40);
    end
    @(negedge clk);
    checkOutput("pn_b1_valid", 64'(out_valid), 64'd1);
    checkOutput("pn_b1_last", 64'(out_last), 64'd0);
    checkBlockOutput("pn_b1_block", out_block, expBlk);
    consumeBlock();
    @(negedge clk);
    expBlk = '0;
    expBlk[0 +: 64]    = 64'h0000000000000006;
    expBlk[64*8 +: 64] = 64'h8000000000000000;
    checkOutput("pn_b2_valid", 64'(out_valid), 64'd1);
    checkOutput("pn_b2_ready", 64'(in_ready), 64'd0);
    checkOutput("pn_b2_last", 64'(out_last), 64'd1);
    checkBlockOutput("pn_b2_block", out_block, expBlk);
    consumeBlock();

    // SHA3-384, 20 words with in_mode toggling mid-message and backpressure.
    expBlk = '0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(wordPat(i + 100), 1'b0, 4'd8, (i == 0) ? 2'b01 : 2'(i));
      expBlk[64*i +: 64] = wordPat(i + 100);
    end
    heldBlk = expBlk;
    // Offer a stray word while the block is held; it must not be taken.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 64'hDEADDEADDEADDEAD;
      in_mode  = 2'b11;
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkBlockOutput("bp_block_stable", out_block, heldBlk);
    end
    in_valid = 1'b0;
    checkOutput("bp_b1_last", 64'(out_last), 64'd0);
    checkOutput("bp_b1_mode", 64'(out_mode), 64'd1);
    consumeBlock();
    @(negedge clk);
    checkOutput("bp_ready_after", 64'(in_ready), 64'd1);
    expBlk = '0;
    for (int i = 13; i < 20; i++) begin
      applyStimulus(wordPat(i + 100), (i == 19), (i == 19) ? 4'd5 : 4'd8, 2'(i));
      expBlk[64*(i - 13) +: 64] = wordPat(i + 100);
    end
    expBlk[64*6 + 40 +: 24] = 24'h000006;
    expBlk[64*12 + 56 +: 8] = 8'h80;
    @(negedge clk);
    checkOutput("bp_b2_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_b2_last", 64'(out_last), 64'd1);
    checkOutput("bp_b2_mode", 64'(out_mode), 64'd1);
    checkBlockOutput("bp_b2_block", out_block, expBlk);
    consumeBlock();

    // Reset after 5 words of a SHA3-224 message; partial block is discarded.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(wordPat(i + 200), 1'b0, 4'd8, 2'b10);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mrst_out_mode", 64'(out_mode), 64'd0);
    checkOutput("mrst_in_ready", 64'(in_ready), 64'd1);
    checkBlockOutput("mrst_out_block", out_block, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // "abc" again, with junk above the valid bytes: same block as before.
    applyStimulus(64'hFFFFFFFFFF636261, 1'b1, 4'd3, 2'b00);
    @(negedge clk);
    expBlk = '0;
    expBlk[0 +: 64]    = 64'h0000000006636261;
    expBlk[64*8 +: 64] = 64'h8000000000000000;
    checkOutput("abc2_valid", 64'(out_valid), 64'd1);
    checkOutput("abc2_last", 64'(out_last), 64'd1);
    checkOutput("abc2_mode", 64'(out_mode), 64'd0);
    checkBlockOutput("abc2_block", out_block, expBlk);
    consumeBlock();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sha3_padder.md
# sha3_padder

Message absorber front-end for the SHA3 core. It collects a 64-bit little-endian word stream into a 1152-bit rate block, applies SHA3 domain padding (0x06 … 0x80) at the end of the message, and hands each block with its mode to the state-XOR stage. That stage XORs the rate portion of the Keccak state with this block.

## Interface
Parameters: none. Rate widths are fixed by mode.

Ports:
- clk  in  1  clock; all flops rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_mode  in  2  hash select, sampled with the first word of a message: 00 SHA3-512 (9 lanes), 01 SHA3-384 (13), 10 SHA3-224 (18), 11 SHA3-256 (17)
- in_valid  in  1  word valid
- in_ready  out  1  word accepted when in_valid & in_ready
- in_data  in  64  message word; byte k at bits [8k+7:8k]
- in_last  in  1  final word of message
- in_bytes  in  4  valid bytes of the final word, 0..8, low bytes; ignored when in_last=0 (treated as 8); values >8 treated as 8
- out_block  out  1152  padded rate block; lane j at bits [64j+63:64j]; lanes ≥ rate lanes are zero
- out_mode  out  2  mode of the message the block belongs to
- out_last  out  1  block is the final block of the message
- out_valid  out  1  block valid
- out_ready  in  1  block consumed when out_valid & out_ready

## Operation
- States: FILL (accepting words), FULL (holding block), FULL_PADNEXT (holding a full non-final block; a pad-only block follows).
- Registers: 1152-bit buffer, 5-bit lane counter (0..17), 2-bit message mode, "in message" flag.
- FILL: in_ready=1. On accept, write the word's valid bytes into lane[cnt] and zero its invalid bytes. Mode latches on the first word when the "in message" flag is clear. in_mode is ignored mid-message.
- Non-last accept with cnt = R-1 (R = rate lanes): go to FULL with out_last=0 and cnt←0. Otherwise cnt←cnt+1.
- Last accept with in_bytes = b < 8: OR 0x06 into byte b of lane[cnt]. OR 0x80 into byte 7 of lane R-1; if both land on the same byte it becomes 0x86. Go to FULL with out_last=1.
- Last accept with b = 8 and cnt < R-1: 0x06 goes into byte 0 of lane[cnt+1], and 0x80 goes into lane R-1 as above. If cnt+1 = R-1, that byte 0 is 0x06 and byte 7 is 0x80. Go to FULL with out_last=1.
- Last accept with b = 8 and cnt = R-1: go to FULL_PADNEXT with out_last=0.
- FULL / FULL_PADNEXT: out_valid=1, in_ready=0. out_block, out_mode and out_last are stable until handshake.
- FULL handshake: clear the buffer and cnt, go to FILL. If out_last=1, also clear the "in message" flag.
- FULL_PADNEXT handshake: load the buffer with lane0 byte0 = 0x06, lane R-1 byte7 = 0x80, all else zero. Go to FULL with out_last=1.
- Buffer bits ≥ 64R are never written and stay zero.
- Empty message: in_last=1 and in_bytes=0 as the first word produces a single pad-only block.

## Timing
- Reset (async, rst_n low): state FILL, buffer 0, cnt 0, flag 0.
  - Output reset values: out_valid=0, out_last=0, out_mode=00, out_block=0, in_ready=1.
  - The source must not assert in_valid while rst_n is low.
- Throughput: one word per cycle in FILL.
- Latency: the word completing a block (or the last word) is accepted at edge t; out_valid=1 from t+1.
- in_ready is decoded from state only and has no combinational path from out_ready.
- After a FULL handshake at edge t, in_ready=1 from t+1. A word cannot be accepted in the handshake cycle.
- After a FULL_PADNEXT handshake at edge t, out_valid stays 1 at t+1 with the pad block.
- Backpressure: with out_ready low, the block and all out_* signals hold indefinitely.
- Reset mid-message or mid-hold: the partial block is discarded, with no output glitch beyond the asynchronous clear.

## Test plan
- Empty message, mode 11: in_last=1, in_bytes=0 → one block with lane0=0x06, lane16=0x8000000000000000, other lanes 0, out_last=1, out_mode=11.
- "abc", mode 00: in_data=0x0000000000636261, in_bytes=3, last → lane0=0x0000000006636261, lane8=0x8000000000000000, lanes 9..17=0, out_last=1, out_valid one cycle after accept.
- Mode 10, 18 words, last word in_bytes=7 → lane17 byte7=0x86, out_last=1, single block.
- Mode 00, 9 full words, last in_bytes=8 → block 1 has out_last=0 and the 9 words. Block 2 follows the cycle after handshake: lane0=0x06, lane8=0x8000000000000000, out_last=1.
- Backpressure and multi-block, mode 01: 20 words; hold out_ready=0 for 10 cycles on block 1 → in_ready=0 and out_block stable throughout. Block 2 holds words 13..19 plus padding. Toggling in_mode mid-message leaves out_mode=01.
- Reset mid-message: drop rst_n after 5 words → all outputs at reset values. A subsequent "abc" message yields the same result as scenario 2.
